// File: rtl/ual_arbiter.sv
// ---------------------------------------------------------------------------
// ual_arbiter
//   Shares one 4-bit UAL (mul/add/sub/logic, 8-bit result) between two
//   requesters. A request is granted round-robin and its operands and opcode
//   are registered onto the UAL pins. The block waits the op-dependent
//   latency, captures the UAL result and returns it on the owner's response
//   channel. Only one transaction is in flight at a time.
//
// Handshake rule (both request and response channels): a transfer happens on
//   the rising edge where valid and ready are both high. Request valid may
//   drop before acceptance. A response holds valid and data stable until it
//   is consumed.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   reqN_valid/op/a/b       request from requester N (N = 0, 1)
//   reqN_ready              combinational grant, IDLE only
//   rspN_valid/data/ready   response to requester N; data is 0 for non-owner
//   ual_a/ual_b/ual_op      registered operands/opcode to the UAL
//   ual_c                   combinational UAL result
//   busy                    high in any state other than IDLE
//   o_dbg_state             FSM state (0 IDLE, 1 EXEC, 2 RESP)
// ---------------------------------------------------------------------------
module ual_arbiter #(
    parameter int MUL_LAT = 2
) (
    input  logic       clk,
    input  logic       rst_n,

    input  logic       req0_valid,
    input  logic [3:0] req0_op,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    output logic       req0_ready,
    output logic       rsp0_valid,
    input  logic       rsp0_ready,
    output logic [7:0] rsp0_data,

    input  logic       req1_valid,
    input  logic [3:0] req1_op,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic       req1_ready,
    output logic       rsp1_valid,
    input  logic       rsp1_ready,
    output logic [7:0] rsp1_data,

    output logic [3:0] ual_a,
    output logic [3:0] ual_b,
    output logic [3:0] ual_op,
    input  logic [7:0] ual_c,

    output logic       busy,
    output logic [1:0] o_dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Latencies below 1 are clamped so the counter always loads a legal value.
    localparam int LAT = (MUL_LAT < 1) ? 1 : MUL_LAT;
    localparam int CW  = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0] MUL_LOAD = CW'(LAT - 1);

    logic [1:0]    r_state;
    logic          r_last;
    logic          r_owner;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_ual_a;
    logic [3:0]    r_ual_b;
    logic [3:0]    r_ual_op;
    logic [7:0]    r_result;

    logic          w_idle;
    logic          w_grant0;
    logic          w_grant1;
    logic          w_accept;
    logic [3:0]    w_sel_op;
    logic [3:0]    w_sel_a;
    logic [3:0]    w_sel_b;
    logic          w_sel_mul;
    logic          w_consume;

    // Requester 0 wins a tie unless it was the last one served. Gating with
    // rst_n keeps ready low while reset is asserted.
    assign w_idle   = rst_n && (r_state == S_IDLE);
    assign w_grant0 = req0_valid && (!req1_valid || r_last);
    assign w_grant1 = req1_valid && (!req0_valid || !r_last);

    assign req0_ready = w_idle && w_grant0;
    assign req1_ready = w_idle && w_grant1;
    assign w_accept   = req0_ready || req1_ready;

    assign w_sel_op  = req1_ready ? req1_op : req0_op;
    assign w_sel_a   = req1_ready ? req1_a  : req0_a;
    assign w_sel_b   = req1_ready ? req1_b  : req0_b;
    // Opcode 0 and the whole upper half (8-15) use the multiplier path.
    assign w_sel_mul = (w_sel_op == 4'd0) || w_sel_op[3];

    assign rsp0_valid = (r_state == S_RESP) && !r_owner;
    assign rsp1_valid = (r_state == S_RESP) &&  r_owner;
    assign rsp0_data  = rsp0_valid ? r_result : 8'h00;
    assign rsp1_data  = rsp1_valid ? r_result : 8'h00;
    assign w_consume  = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

    assign ual_a       = r_ual_a;
    assign ual_b       = r_ual_b;
    assign ual_op      = r_ual_op;
    assign busy        = (r_state != S_IDLE);
    assign o_dbg_state = r_state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_last   <= 1'b1;
            r_owner  <= 1'b0;
            r_cnt    <= '0;
            r_ual_a  <= 4'h0;
            r_ual_b  <= 4'h0;
            r_ual_op <= 4'h0;
            r_result <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_ual_op <= w_sel_op;
                        r_ual_a  <= w_sel_a;
                        r_ual_b  <= w_sel_b;
                        r_owner  <= req1_ready;
                        r_cnt    <= w_sel_mul ? MUL_LOAD : '0;
                        r_state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // Count 0 marks the last execute cycle: ual_c is settled.
                    if (r_cnt == '0) begin
                        r_result <= ual_c;
                        r_state  <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_RESP: begin
                    if (w_consume) begin
                        r_last  <= r_owner;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ual_arbiter.sv
module tb_ual_arbiter;

    localparam int MUL_LAT = 3;

    logic       clk;
    logic       rst_n;
    logic       req0_valid, req0_ready, rsp0_valid, rsp0_ready;
    logic [3:0] req0_op, req0_a, req0_b;
    logic [7:0] rsp0_data;
    logic       req1_valid, req1_ready, rsp1_valid, rsp1_ready;
    logic [3:0] req1_op, req1_a, req1_b;
    logic [7:0] rsp1_data;
    logic [3:0] ual_a, ual_b, ual_op;
    logic [7:0] ual_c;
    logic       busy;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    ual_arbiter #(.MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_data(rsp0_data),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_data(rsp1_data),
        .ual_a(ual_a), .ual_b(ual_b), .ual_op(ual_op), .ual_c(ual_c),
        .busy(busy), .o_dbg_state(dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural UAL: operands zero-extended to 8 bits, result kept as 8 bits.
    function automatic logic [7:0] ual_fn(input logic [3:0] op, input logic [3:0] a,
                                          input logic [3:0] b);
        logic [7:0] ea;
        logic [7:0] eb;
        ea = {4'h0, a};
        eb = {4'h0, b};
        case (op)
            4'd1:    return ea + eb;
            4'd2:    return ea - eb;
            4'd3:    return ea & eb;
            4'd4:    return ea | eb;
            4'd5:    return ea ^ eb;
            4'd6:    return ~(ea & eb);
            4'd7:    return ~(ea | eb);
            default: return ea * eb;
        endcase
    endfunction

    function automatic int lat_of(input logic [3:0] op);
        return (op >= 4'd1 && op <= 4'd7) ? 1 : MUL_LAT;
    endfunction

    assign ual_c = ual_fn(ual_op, ual_a, ual_b);

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_op = 4'h0; req0_a = 4'h0; req0_b = 4'h0;
        req1_valid = 1'b0; req1_op = 4'h0; req1_a = 4'h0; req1_b = 4'h0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        tick();
        tick();
        @(negedge clk);
        n_checks++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req0_ready: got %0h want 0", req0_ready); end
        n_checks++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req1_ready: got %0h want 0", req1_ready); end
        n_checks++; if (rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp0_valid: got %0h want 0", rsp0_valid); end
        n_checks++; if (rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp1_valid: got %0h want 0", rsp1_valid); end
        n_checks++; if (rsp0_data !== 8'h00) begin n_fail++; $display("FAIL rst_rsp0_data: got %0h want 0", rsp0_data); end
        n_checks++; if (rsp1_data !== 8'h00) begin n_fail++; $display("FAIL rst_rsp1_data: got %0h want 0", rsp1_data); end
        n_checks++; if (ual_a !== 4'h0) begin n_fail++; $display("FAIL rst_ual_a: got %0h want 0", ual_a); end
        n_checks++; if (ual_b !== 4'h0) begin n_fail++; $display("FAIL rst_ual_b: got %0h want 0", ual_b); end
        n_checks++; if (ual_op !== 4'h0) begin n_fail++; $display("FAIL rst_ual_op: got %0h want 0", ual_op); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0h want 0", busy); end
        n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0h want 0", dbg_state); end
        tick();
        rst_n = 1'b1;
        idle_inputs();
        tick();
    endtask

    task automatic test_single_add();
        req0_valid = 1'b1; req0_op = 4'd1; req0_a = 4'd9; req0_b = 4'd8; rsp0_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL add_req0_ready: got %0h want 1", req0_ready); end
        n_checks++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL add_req1_ready: got %0h want 0", req1_ready); end
        tick();
        req0_valid = 1'b0; req0_a = 4'($urandom); req0_b = 4'($urandom);
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL add_busy_c1: got %0h want 1", busy); end
        n_checks++; if ({ual_op, ual_a, ual_b} !== 12'h198) begin n_fail++; $display("FAIL add_ual_regs: got %0h want 198", {ual_op, ual_a, ual_b}); end
        n_checks++; if (rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL add_rsp0_early: got %0h want 0", rsp0_valid); end
        tick();
        @(negedge clk);
        n_checks++; if (rsp0_valid !== 1'b1) begin n_fail++; $display("FAIL add_rsp0_valid: got %0h want 1", rsp0_valid); end
        n_checks++; if (rsp0_data !== 8'h11) begin n_fail++; $display("FAIL add_rsp0_data: got %0h want 11", rsp0_data); end
        n_checks++; if (rsp1_valid !== 1'b0 || rsp1_data !== 8'h00) begin n_fail++; $display("FAIL add_rsp1_idle: got %0h/%0h want 0/0", rsp1_valid, rsp1_data); end
        tick();
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL add_busy_c3: got %0h want 0", busy); end
        n_checks++; if (rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL add_rsp0_drop: got %0h want 0", rsp0_valid); end
        tick();
    endtask

    task automatic test_tie();
        int grants[$];
        int exp_g[3];
        int n0;
        int n1;
        exp_g = '{0, 1, 0};
        n0 = 0;
        n1 = 0;
        do_reset();
        req0_op = 4'd3; req0_a = 4'hC; req0_b = 4'hA;
        req1_op = 4'd4; req1_a = 4'hC; req1_b = 4'hA;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            req0_valid = (grants.size() < 3);
            req1_valid = (grants.size() < 3);
            @(negedge clk);
            if (req0_valid && req0_ready) grants.push_back(0);
            if (req1_valid && req1_ready) grants.push_back(1);
            n_checks++; if (rsp0_valid && rsp1_valid) begin n_fail++; $display("FAIL tie_both_valid: cycle %0d both rsp valid", c); end
            if (rsp0_valid) begin
                n0++;
                n_checks++; if (rsp0_data !== 8'h08) begin n_fail++; $display("FAIL tie_rsp0_data: got %0h want 08", rsp0_data); end
            end
            if (rsp1_valid) begin
                n1++;
                n_checks++; if (rsp1_data !== 8'h0E) begin n_fail++; $display("FAIL tie_rsp1_data: got %0h want 0e", rsp1_data); end
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= grants.size()) begin
                n_fail++; $display("FAIL tie_grant%0d: got none want %0d", i, exp_g[i]);
            end else if (grants[i] != exp_g[i]) begin
                n_fail++; $display("FAIL tie_grant%0d: got %0d want %0d", i, grants[i], exp_g[i]);
            end
        end
        n_checks++; if (n0 != 2 || n1 != 1) begin n_fail++; $display("FAIL tie_rsp_count: got %0d/%0d want 2/1", n0, n1); end
    endtask

    task automatic test_mul_latency();
        idle_inputs();
        req1_valid = 1'b1; req1_op = 4'd0; req1_a = 4'd3; req1_b = 4'd5;
        @(negedge clk);
        n_checks++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL mul_req1_ready: got %0h want 1", req1_ready); end
        tick();
        req1_valid = 1'b0; req1_op = 4'd1; req1_a = 4'($urandom); req1_b = 4'($urandom);
        for (int c = 1; c <= MUL_LAT; c++) begin
            @(negedge clk);
            n_checks++; if ({ual_op, ual_a, ual_b} !== 12'h035) begin n_fail++; $display("FAIL mul_ual_hold c%0d: got %0h want 035", c, {ual_op, ual_a, ual_b}); end
            n_checks++; if (rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL mul_rsp1_early c%0d: got %0h want 0", c, rsp1_valid); end
            tick();
        end
        @(negedge clk);
        n_checks++; if (rsp1_valid !== 1'b1) begin n_fail++; $display("FAIL mul_rsp1_valid: got %0h want 1", rsp1_valid); end
        n_checks++; if (rsp1_data !== 8'h0F) begin n_fail++; $display("FAIL mul_rsp1_data: got %0h want 0f", rsp1_data); end
        n_checks++; if (rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL mul_rsp0_quiet: got %0h want 0", rsp0_valid); end
        tick();
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mul_busy_end: got %0h want 0", busy); end
        tick();
    endtask

    task automatic test_backpressure();
        idle_inputs();
        req0_valid = 1'b1; req0_op = 4'd2; req0_a = 4'd3; req0_b = 4'd5;
        req1_valid = 1'b1; req1_op = 4'd1; req1_a = 4'd1; req1_b = 4'd1;
        rsp0_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL bp_grant: got %0h/%0h want 1/0", req0_ready, req1_ready); end
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL bp_req1_exec: got %0h want 0", req1_ready); end
        tick();
        for (int c = 2; c <= 7; c++) begin
            rsp0_ready = (c == 7);
            @(negedge clk);
            n_checks++; if (rsp0_valid !== 1'b1 || rsp0_data !== 8'hFE) begin n_fail++; $display("FAIL bp_hold c%0d: got %0h/%0h want 1/fe", c, rsp0_valid, rsp0_data); end
            n_checks++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL bp_req1_blocked c%0d: got %0h want 0", c, req1_ready); end
            tick();
        end
        @(negedge clk);
        n_checks++; if (rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL bp_rsp0_drop: got %0h want 0", rsp0_valid); end
        n_checks++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL bp_req1_ready: got %0h want 1", req1_ready); end
        tick();
        req1_valid = 1'b0;
        @(negedge clk);
        tick();
        @(negedge clk);
        n_checks++; if (rsp1_valid !== 1'b1 || rsp1_data !== 8'h02) begin n_fail++; $display("FAIL bp_rsp1: got %0h/%0h want 1/02", rsp1_valid, rsp1_data); end
        tick();
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_busy_end: got %0h want 0", busy); end
        tick();
    endtask

    task automatic test_reset_exec();
        logic saw;
        logic got;
        idle_inputs();
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = 4'd7; req0_b = 4'd7;
        @(negedge clk);
        n_checks++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL rx_accept: got %0h want 1", req0_ready); end
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rx_busy: got %0h want 1", busy); end
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy} !== 5'b0) begin n_fail++; $display("FAIL rx_ctrl_zero: got %b want 00000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy}); end
        n_checks++; if ({rsp0_data, rsp1_data} !== 16'h0) begin n_fail++; $display("FAIL rx_data_zero: got %0h want 0", {rsp0_data, rsp1_data}); end
        n_checks++; if ({ual_op, ual_a, ual_b} !== 12'h0) begin n_fail++; $display("FAIL rx_ual_zero: got %0h want 0", {ual_op, ual_a, ual_b}); end
        tick();
        saw = 1'b0;
        for (int c = 0; c < MUL_LAT + 4; c++) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid) saw = 1'b1;
            tick();
        end
        n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL rx_ghost_rsp: got %0h want 0", saw); end
        req0_valid = 1'b1; req0_op = 4'd6; req0_a = 4'hF; req0_b = 4'hF;
        got = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (req0_ready) begin
                tick();
                req0_valid = 1'b0;
                @(negedge clk);
            end
            if (rsp0_valid && !got) begin
                got = 1'b1;
                n_checks++; if (rsp0_data !== 8'hF0) begin n_fail++; $display("FAIL rx_nand_data: got %0h want f0", rsp0_data); end
            end
            tick();
        end
        n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL rx_nand_timeout: got no response want one"); end
        idle_inputs();
    endtask

    task automatic test_upper_opcode();
        idle_inputs();
        req1_valid = 1'b1; req1_op = 4'd9; req1_a = 4'd2; req1_b = 4'd7;
        @(negedge clk);
        n_checks++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL up_accept: got %0h want 1", req1_ready); end
        tick();
        req1_valid = 1'b0;
        for (int c = 1; c <= MUL_LAT; c++) begin
            @(negedge clk);
            n_checks++; if (rsp1_valid !== 1'b0 || ual_op !== 4'd9) begin n_fail++; $display("FAIL up_exec c%0d: got %0h/%0h want 0/9", c, rsp1_valid, ual_op); end
            tick();
        end
        @(negedge clk);
        n_checks++; if (rsp1_valid !== 1'b1 || rsp1_data !== 8'h0E) begin n_fail++; $display("FAIL up_rsp1: got %0h/%0h want 1/0e", rsp1_valid, rsp1_data); end
        tick();
        @(negedge clk);
        tick();
    endtask

    // Randomized traffic against a transaction-level reference model.
    task automatic test_random();
        logic [7:0] exp_q[$];
        bit m_busy, m_last, m_owner;
        bit e_r0, e_r1, e_v0, e_v1;
        logic [7:0] e_d0, e_d1;
        logic [3:0] m_op, op, a, b;
        int m_age, m_lat;
        m_busy = 0; m_last = 1; m_owner = 0; m_age = 0; m_lat = 1; m_op = 4'h0;
        do_reset();
        for (int c = 0; c < 420; c++) begin
            if (c < 400) begin
                req0_valid = ($urandom_range(0, 3) != 0);
                req1_valid = ($urandom_range(0, 3) != 0);
                req0_op = 4'($urandom); req0_a = 4'($urandom); req0_b = 4'($urandom);
                req1_op = 4'($urandom); req1_a = 4'($urandom); req1_b = 4'($urandom);
                rsp0_ready = ($urandom_range(0, 2) != 0);
                rsp1_ready = ($urandom_range(0, 2) != 0);
            end else begin
                idle_inputs();
            end
            @(negedge clk);
            e_r0 = !m_busy && req0_valid && (!req1_valid || m_last);
            e_r1 = !m_busy && req1_valid && (!req0_valid || !m_last);
            e_v0 = m_busy && !m_owner && (m_age > m_lat);
            e_v1 = m_busy &&  m_owner && (m_age > m_lat);
            e_d0 = e_v0 ? exp_q[0] : 8'h00;
            e_d1 = e_v1 ? exp_q[0] : 8'h00;
            n_checks++; if (req0_ready !== e_r0 || req1_ready !== e_r1) begin n_fail++; $display("FAIL rnd_ready c%0d: got %0h/%0h want %0h/%0h", c, req0_ready, req1_ready, e_r0, e_r1); end
            n_checks++; if (rsp0_valid !== e_v0 || rsp1_valid !== e_v1) begin n_fail++; $display("FAIL rnd_rsp_valid c%0d: got %0h/%0h want %0h/%0h", c, rsp0_valid, rsp1_valid, e_v0, e_v1); end
            n_checks++; if (rsp0_data !== e_d0 || rsp1_data !== e_d1) begin n_fail++; $display("FAIL rnd_rsp_data c%0d: got %0h/%0h want %0h/%0h", c, rsp0_data, rsp1_data, e_d0, e_d1); end
            n_checks++; if (busy !== m_busy) begin n_fail++; $display("FAIL rnd_busy c%0d: got %0h want %0h", c, busy, m_busy); end
            if (m_busy) begin
                n_checks++; if (ual_op !== m_op) begin n_fail++; $display("FAIL rnd_ual_op c%0d: got %0h want %0h", c, ual_op, m_op); end
                if ((e_v0 && rsp0_ready) || (e_v1 && rsp1_ready)) begin
                    m_busy = 0;
                    m_last = m_owner;
                    void'(exp_q.pop_front());
                end else begin
                    m_age++;
                end
            end else if (e_r0 || e_r1) begin
                op = e_r1 ? req1_op : req0_op;
                a  = e_r1 ? req1_a  : req0_a;
                b  = e_r1 ? req1_b  : req0_b;
                m_busy = 1; m_owner = e_r1; m_age = 1; m_op = op; m_lat = lat_of(op);
                exp_q.push_back(ual_fn(op, a, b));
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_single_add();
        test_tie();
        test_mul_latency();
        test_backpressure();
        test_reset_exec();
        test_upper_opcode();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
